// File: rtl/battle_ctrl.sv
// Turn sequencer for the battle datapath: one player attack then one AI attack
// per go press, each gated by an accuracy roll, until either side is knocked out.
module battle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [1:0] pl_sel,
    input  logic [3:0] p_hp,
    input  logic [3:0] ai_hp,
    input  logic [3:0] accu,
    input  logic [3:0] roll,
    output logic [1:0] p_move,
    output logic       actr,
    output logic       target,
    output logic       load_ai_hp,
    output logic       app_ai_dmg,
    output logic       app_pl_dmg,
    output logic       stop,
    output logic       hit,
    output logic [4:0] turn_cnt,
    output logic       winner,
    output logic       done,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        P_SEL   = 4'd1,
        P_LOAD  = 4'd2,
        P_APPLY = 4'd3,
        P_CHECK = 4'd4,
        A_SEL   = 4'd5,
        A_WAIT  = 4'd6,
        A_APPLY = 4'd7,
        A_CHECK = 4'd8,
        OVER    = 4'd9
    } state_t;

    state_t cur, nxt;
    logic   go_q;
    logic   go_edge;
    logic   hit_c;

    assign go_edge = go & ~go_q;
    assign hit_c   = (accu >= roll);
    assign state   = cur;

    always_comb begin
        nxt        = IDLE;
        stop       = 1'b1;
        actr       = 1'b0;
        target     = 1'b0;
        load_ai_hp = 1'b0;
        app_ai_dmg = 1'b0;
        app_pl_dmg = 1'b0;
        done       = 1'b0;
        case (cur)
            IDLE: begin
                stop = 1'b0;
                nxt  = go_edge ? P_SEL : IDLE;
            end
            P_SEL: begin
                target = 1'b1;
                nxt    = P_LOAD;
            end
            P_LOAD: begin
                target     = 1'b1;
                load_ai_hp = 1'b1;
                nxt        = P_APPLY;
            end
            P_APPLY: begin
                target     = 1'b1;
                app_ai_dmg = hit_c;
                nxt        = P_CHECK;
            end
            P_CHECK: begin
                target = 1'b1;
                nxt    = (ai_hp == 4'd0) ? OVER : A_SEL;
            end
            A_SEL: begin
                actr = 1'b1;
                nxt  = A_WAIT;
            end
            A_WAIT: begin
                actr = 1'b1;
                nxt  = A_APPLY;
            end
            A_APPLY: begin
                actr       = 1'b1;
                app_pl_dmg = hit_c;
                nxt        = A_CHECK;
            end
            A_CHECK: begin
                actr = 1'b1;
                nxt  = (p_hp == 4'd0) ? OVER : IDLE;
            end
            OVER: begin
                done = 1'b1;
                nxt  = OVER;
            end
            default: nxt = IDLE;
        endcase
    end

    // go_q resets high so a button held through reset release is not a press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur      <= IDLE;
            go_q     <= 1'b1;
            p_move   <= '0;
            hit      <= 1'b0;
            winner   <= 1'b0;
            turn_cnt <= '0;
        end else begin
            cur  <= nxt;
            go_q <= go;
            if (cur == IDLE && go_edge)
                p_move <= pl_sel;
            if (cur == P_APPLY || cur == A_APPLY)
                hit <= hit_c;
            if (cur == P_CHECK && ai_hp == 4'd0)
                winner <= 1'b1;
            if (cur == A_CHECK) begin
                if (p_hp == 4'd0)
                    winner <= 1'b0;
                else if (turn_cnt != '1)
                    turn_cnt <= turn_cnt + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_battle_ctrl.sv
// Self-checking bench for battle_ctrl: directed turn table, KO and reset
// sequences, and randomized turns against a per-turn behavioural model.
module tb_battle_ctrl;

    logic       clk;
    logic       rst;
    logic       go;
    logic [1:0] pl_sel;
    logic [3:0] p_hp, ai_hp, accu, roll;
    logic [1:0] p_move;
    logic       actr, target, load_ai_hp, app_ai_dmg, app_pl_dmg, stop, hit;
    logic [4:0] turn_cnt;
    logic       winner, done;
    logic [3:0] state;

    int n_checks;
    int n_fail;

    int         m_cnt;
    logic       m_hit;
    logic       m_win;
    logic [1:0] m_pmove;

    battle_ctrl dut (
        .clk(clk), .rst(rst), .go(go), .pl_sel(pl_sel),
        .p_hp(p_hp), .ai_hp(ai_hp), .accu(accu), .roll(roll),
        .p_move(p_move), .actr(actr), .target(target),
        .load_ai_hp(load_ai_hp), .app_ai_dmg(app_ai_dmg), .app_pl_dmg(app_pl_dmg),
        .stop(stop), .hit(hit), .turn_cnt(turn_cnt), .winner(winner),
        .done(done), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // {stop, actr, target, done} as the datapath should see them in state s
    function automatic logic [3:0] exp_ctrl(input int unsigned s);
        return {s != 0, (s >= 5 && s <= 8), (s >= 1 && s <= 4), s == 9};
    endfunction

    // Plays one turn starting from IDLE at a negedge; ends at the negedge in the final state.
    task automatic run_turn(input logic [1:0] sel, input logic [3:0] a, input logic [3:0] r,
                            input logic [3:0] aip, input logic [3:0] pp, input bit jitter);
        int unsigned exp_q[$];
        logic h;
        h = (a >= r);
        exp_q = '{1, 2, 3, 4};
        if (aip == 0) exp_q.push_back(9);
        else begin
            exp_q.push_back(5); exp_q.push_back(6); exp_q.push_back(7); exp_q.push_back(8);
            exp_q.push_back(pp == 0 ? 9 : 0);
        end
        go = 1'b0; pl_sel = sel; accu = a; roll = r; ai_hp = 4'd15; p_hp = 4'd15;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            int unsigned s;
            s = exp_q[i];
            if (s == 1) m_pmove = sel;
            if (s == 4) m_hit = h;
            if (s == 9) m_win = (aip == 0);
            if (s == 0) m_cnt = (m_cnt >= 31) ? 31 : m_cnt + 1;
            chk("state", 8'(state), 8'(s));
            chk("strobes", {5'd0, load_ai_hp, app_ai_dmg, app_pl_dmg},
                {5'd0, s == 2, s == 3 && h, s == 7 && h});
            chk("ctrl", {4'd0, stop, actr, target, done}, {4'd0, exp_ctrl(s)});
            chk("p_move", 8'(p_move), 8'(m_pmove));
            chk("hit", 8'(hit), 8'(m_hit));
            chk("turn_cnt", 8'(turn_cnt), 8'(m_cnt));
            if (s == 9) chk("winner", 8'(winner), 8'(m_win));
            if (i + 1 < exp_q.size()) begin
                if (s == 3) ai_hp = aip;
                if (s == 7) p_hp = pp;
                if (jitter) begin
                    go = 1'($urandom_range(0, 1));
                    pl_sel = 2'($urandom);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic check_idle_reset(input string tag);
        chk({tag, "_state"}, 8'(state), 8'd0);
        chk({tag, "_strobes"}, {5'd0, load_ai_hp, app_ai_dmg, app_pl_dmg}, 8'd0);
        chk({tag, "_ctrl"}, {4'd0, stop, actr, target, done}, 8'd0);
        chk({tag, "_regs"}, {hit, winner, p_move, 4'd0}, 8'd0);
        chk({tag, "_turn_cnt"}, 8'(turn_cnt), 8'd0);
    endtask

    // Starts a turn, advances k cycles past P_SEL, then asserts rst between edges.
    task automatic abort_turn(input int k, input logic [3:0] exp_st, input logic exp_load);
        go = 1'b0; pl_sel = 2'd1; accu = 4'd15; roll = 4'd0; ai_hp = 4'd15; p_hp = 4'd15;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        repeat (k) @(negedge clk);
        chk("abort_pre_state", 8'(state), 8'(exp_st));
        chk("abort_pre_load", 8'(load_ai_hp), 8'(exp_load));
        #2 rst = 1'b1;
        #1 check_idle_reset("async_rst");
        @(negedge clk);
        rst = 1'b0; go = 1'b0;
        m_cnt = 0; m_hit = 1'b0; m_win = 1'b0; m_pmove = 2'd0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0] sel;
        logic [3:0] a, r, aip, pp;
        logic       exp_hit;
        logic [3:0] exp_end;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{sel: 2'd2, a: 4'd15, r: 4'd7,  aip: 4'd12, pp: 4'd13, exp_hit: 1'b1, exp_end: 4'd0};
        vecs[1] = '{sel: 2'd1, a: 4'd3,  r: 4'd9,  aip: 4'd15, pp: 4'd15, exp_hit: 1'b0, exp_end: 4'd0};
        vecs[2] = '{sel: 2'd0, a: 4'd8,  r: 4'd8,  aip: 4'd10, pp: 4'd9,  exp_hit: 1'b1, exp_end: 4'd0};
        vecs[3] = '{sel: 2'd3, a: 4'd0,  r: 4'd0,  aip: 4'd5,  pp: 4'd5,  exp_hit: 1'b1, exp_end: 4'd0};
        vecs[4] = '{sel: 2'd1, a: 4'd0,  r: 4'd1,  aip: 4'd4,  pp: 4'd4,  exp_hit: 1'b0, exp_end: 4'd0};
        vecs[5] = '{sel: 2'd2, a: 4'd14, r: 4'd15, aip: 4'd1,  pp: 4'd1,  exp_hit: 1'b0, exp_end: 4'd0};

        n_checks = 0; n_fail = 0;
        m_cnt = 0; m_hit = 1'b0; m_win = 1'b0; m_pmove = 2'd0;
        rst = 1'b1; go = 1'b1; pl_sel = 2'd2;
        p_hp = 4'd15; ai_hp = 4'd15; accu = 4'd0; roll = 4'd0;

        // Reset state, then release with go still held: no turn may start
        repeat (2) @(negedge clk);
        check_idle_reset("reset");
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("held_go_state", 8'(state), 8'd0);
            chk("held_go_stop", 8'(stop), 8'd0);
        end

        foreach (vecs[i]) begin
            run_turn(vecs[i].sel, vecs[i].a, vecs[i].r, vecs[i].aip, vecs[i].pp, 1'b0);
            chk("vec_hit", 8'(hit), 8'(vecs[i].exp_hit));
            chk("vec_end", 8'(state), 8'(vecs[i].exp_end));
        end

        // Random non-KO turns with go/pl_sel jitter mid-turn; count saturates at 31
        for (int t = 0; t < 33; t++)
            run_turn(2'($urandom), 4'($urandom), 4'($urandom),
                     4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)), 1'b1);
        chk("turn_cnt_sat", 8'(turn_cnt), 8'd31);

        abort_turn(5, 4'd6, 1'b0);
        abort_turn(1, 4'd2, 1'b1);

        // AI knocks out the player
        run_turn(2'd1, 4'd15, 4'd0, 4'd10, 4'd0, 1'b0);
        chk("ai_ko_done", 8'(done), 8'd1);
        chk("ai_ko_winner", 8'(winner), 8'd0);
        chk("ai_ko_cnt", 8'(turn_cnt), 8'd0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; go = 1'b0;
        m_cnt = 0; m_hit = 1'b0; m_win = 1'b0; m_pmove = 2'd0;
        @(negedge clk);

        // Player knocks out the AI; later go presses must not leave OVER
        run_turn(2'd3, 4'd15, 4'd2, 4'd0, 4'd15, 1'b0);
        go = 1'b0;
        @(negedge clk);
        go = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("over_state", 8'(state), 8'd9);
            chk("over_done", 8'(done), 8'd1);
            chk("over_winner", 8'(winner), 8'd1);
            chk("over_strobes", {5'd0, load_ai_hp, app_ai_dmg, app_pl_dmg}, 8'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
